seq_sub_32bit: RTL

SEQ_SUB_32BIT -- requirements
Module: seq_sub_32bit

---
 rtl/seq_sub_32bit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seq_sub_32bit.sv
// Slice-serial 32-bit subtractor: computes A - B - b_in over 32/SLICE_W RUN cycles.
// Defining SUB_OVF_EN adds the registered signed-overflow flag; otherwise ovf is tied low.
module seq_sub_32bit #(
  parameter int SLICE_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        b_in,
  output logic [31:0] diff,
  output logic        b_out,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  localparam int N     = 32 / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_sh_q, b_sh_q;
  logic             borrow_q;
  logic [31:0]      diff_q;
  logic             b_out_q;
  logic [SLICE_W:0] slice_full;
  logic             last_slice;

  assign last_slice = (cnt_q == LAST);

  // The extra top bit of the widened slice difference is that slice's borrow-out.
  assign slice_full = {1'b0, a_sh_q[SLICE_W-1:0]}
                    - {1'b0, b_sh_q[SLICE_W-1:0]}
                    - {{SLICE_W{1'b0}}, borrow_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operands shift right as slices are consumed; results shift in from the top,
  // so after N slices slice 0 has arrived at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q   <= A;
            b_sh_q   <= B;
            borrow_q <= b_in;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          diff_q   <= {slice_full[SLICE_W-1:0], diff_q[31:SLICE_W]};
          a_sh_q   <= a_sh_q >> SLICE_W;
          b_sh_q   <= b_sh_q >> SLICE_W;
          borrow_q <= slice_full[SLICE_W];
          cnt_q    <= cnt_q + 1'b1;
          if (last_slice) begin
            b_out_q <= slice_full[SLICE_W];
          end
        end
        default: ;
      endcase
    end
  end

  assign diff  = diff_q;
  assign b_out = b_out_q;

`ifdef SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // Operand sign bits are shifted out during RUN, so they are kept separately.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        a_msb_q <= A[31];
        b_msb_q <= B[31];
      end
      if (state_q == RUN && last_slice) begin
        ovf_q <= (a_msb_q != b_msb_q) && (slice_full[SLICE_W-1] != a_msb_q);
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
